i2c_xact_arbiter: RTL

Transaction-level arbiter that shares one I2C byte-command engine among `NUM_REQ` requesters. The engine emits START, WRITE, READ and STOP on the bus. The arbiter grants the engine to one requester from its START until its STOP completes, and routes each engine response back to that owner. It also forcibly releases a bus left idle by a stalled owner. It sits between the test or system command sources and the engine that drives `scl`/`sda`.

---
 rtl/i2c_types_pkg.sv | 28 ++
 rtl/i2c_xact_arbiter_if.sv | 35 +++
 rtl/i2c_rr_pick.sv | 28 ++
 rtl/i2c_xact_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/i2c_types_pkg.sv
// rtl/i2c_types_pkg.sv - shared I2C command/response types and arbiter state encoding
package i2c_types_pkg;

  typedef enum logic [2:0] {
    I2C_START    = 3'd0,
    I2C_STOP     = 3'd1,
    I2C_WRITE    = 3'd2,
    I2C_READ_ACK = 3'd3,
    I2C_READ_NAK = 3'd4
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_NAK      = 2'd1,
    RSP_ARB_LOST = 2'd2,
    RSP_ABORT    = 2'd3
  } i2c_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_RSP   = 3'd2,
    ST_OWNED      = 3'd3,
    ST_FORCE_STOP = 3'd4,
    ST_FORCE_WAIT = 3'd5
  } arb_state_t;

endpackage

// File: rtl/i2c_xact_arbiter_if.sv
// rtl/i2c_xact_arbiter_if.sv - requester and engine signal bundle around the transaction arbiter
interface i2c_xact_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int I2C_DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0][2:0]                req_cmd_i;
  logic [NUM_REQ-1:0][I2C_DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]                     req_valid_i;
  logic [NUM_REQ-1:0]                     req_ready_o;
  logic [NUM_REQ-1:0]                     rsp_valid_o;
  logic [I2C_DATA_WIDTH-1:0]              rsp_data_o;
  logic [1:0]                             rsp_status_o;
  logic [2:0]                             eng_cmd_o;
  logic [I2C_DATA_WIDTH-1:0]              eng_data_o;
  logic                                   eng_valid_o;
  logic                                   eng_ready_i;
  logic                                   eng_rsp_valid_i;
  logic [I2C_DATA_WIDTH-1:0]              eng_rsp_data_i;
  logic [1:0]                             eng_rsp_status_i;

  // slave: the arbiter; master: command sources plus engine
  modport slave (
    input  req_cmd_i, req_data_i, req_valid_i, eng_ready_i,
           eng_rsp_valid_i, eng_rsp_data_i, eng_rsp_status_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o,
           eng_cmd_o, eng_data_o, eng_valid_o
  );

  modport master (
    output req_cmd_i, req_data_i, req_valid_i, eng_ready_i,
           eng_rsp_valid_i, eng_rsp_data_i, eng_rsp_status_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o,
           eng_cmd_o, eng_data_o, eng_valid_o
  );
endinterface

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker, first request at or after ptr wins
module i2c_rr_pick #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the closest request to ptr is written last
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_xact_arbiter.sv
// rtl/i2c_xact_arbiter.sv - shares one I2C byte-command engine among NUM_REQ requesters
module i2c_xact_arbiter
  import i2c_types_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  I2C_DATA_WIDTH = 8,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int IW             = $clog2(NUM_REQ),
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  i2c_xact_arbiter_if.slave   bus,
  output logic [IW-1:0]       owner_o,
  output logic                busy_o
);

  arb_state_t                state_q, state_d;
  logic [IW-1:0]             owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]             pick_idx, owner_next;
  logic                      pick_any;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic                      stop_q, stop_d;
  logic [NUM_REQ-1:0]        start_req, illegal_req;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [I2C_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]                rsp_status_q, rsp_status_d;

  // Illegal-accept ready is combinational, so it is held off during reset
  always_comb begin
    start_req   = '0;
    illegal_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      start_req[i]   = bus.req_valid_i[i] && (bus.req_cmd_i[i] == I2C_START);
      illegal_req[i] = rst_i && bus.req_valid_i[i] && (bus.req_cmd_i[i] != I2C_START);
    end
  end

  i2c_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (start_req),
    .ptr   (rr_ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  assign owner_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    tcnt_d           = tcnt_q;
    stop_d           = stop_q;
    rsp_valid_d      = '0;
    rsp_data_d       = rsp_data_q;
    rsp_status_d     = rsp_status_q;
    bus.req_ready_o  = '0;
    bus.eng_valid_o  = 1'b0;
    bus.eng_cmd_o    = I2C_START;
    bus.eng_data_o   = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready_o = illegal_req;
        if (|illegal_req) begin
          rsp_valid_d  = illegal_req;
          rsp_data_d   = '0;
          rsp_status_d = RSP_ABORT;
        end
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.eng_valid_o          = 1'b1;
        bus.eng_cmd_o            = bus.req_cmd_i[owner_q];
        bus.eng_data_o           = bus.req_data_i[owner_q];
        bus.req_ready_o[owner_q] = bus.eng_ready_i;
        if (bus.eng_ready_i) begin
          stop_d  = (bus.req_cmd_i[owner_q] == I2C_STOP);
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (bus.eng_rsp_valid_i) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = bus.eng_rsp_data_i;
          rsp_status_d         = bus.eng_rsp_status_i;
          // Lost arbitration means the engine already let go of the bus
          if (stop_q || (bus.eng_rsp_status_i == RSP_ARB_LOST)) begin
            state_d  = ST_IDLE;
            rr_ptr_d = owner_next;
          end else begin
            state_d = ST_OWNED;
            tcnt_d  = '0;
          end
        end
      end
      ST_OWNED: begin
        if (bus.req_valid_i[owner_q]) begin
          state_d = ST_ISSUE;
          tcnt_d  = '0;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
          state_d = ST_FORCE_STOP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_FORCE_STOP: begin
        bus.eng_valid_o = 1'b1;
        bus.eng_cmd_o   = I2C_STOP;
        if (bus.eng_ready_i) begin
          state_d = ST_FORCE_WAIT;
        end
      end
      ST_FORCE_WAIT: begin
        if (bus.eng_rsp_valid_i) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = bus.eng_rsp_data_i;
          rsp_status_d         = RSP_ABORT;
          state_d              = ST_IDLE;
          rr_ptr_d             = owner_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      tcnt_q       <= '0;
      stop_q       <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      tcnt_q       <= tcnt_d;
      stop_q       <= stop_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_status_o = rsp_status_q;
  assign owner_o          = owner_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule
